// File: rtl/load_reg_pkg.sv
// Shared types and helpers for the load-register arbiter.
package load_reg_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Index width that stays at least one bit even for a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
  import load_reg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDXW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    start,
  output logic               valid,
  output logic [IDXW-1:0]    winner
);

  // start + off modulo NUM_REQ; off is always below NUM_REQ.
  function automatic logic [IDXW-1:0] add_wrap(input logic [IDXW-1:0] a, input int off);
    int s;
    s = int'(a) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDXW'(s);
  endfunction

  // Requests rotated so that bit 0 is the requester at the start index.
  logic [NUM_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[add_wrap(start, gi)];
    end
  endgenerate

  // Lowest rotated position wins; scanning downwards lets it overwrite the others.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid  = 1'b1;
        winner = add_wrap(start, k);
      end
    end
  end

endmodule

// File: rtl/load_reg_arbiter.sv
// One shared load register, owned round-robin by NUM_REQ requesters in bursts of at most MAX_BURST loads.
module load_reg_arbiter
  import load_reg_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       clr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic [WIDTH-1:0]           q,
  output logic                       ld_done,
  output logic [idx_width(NUM_REQ)-1:0] ld_src
);

  localparam int IDXW = idx_width(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  state_t              state_reg, state_next;
  logic [IDXW-1:0]     owner_reg, owner_next;
  logic [IDXW-1:0]     last_owner_reg, last_owner_next;
  logic [CNTW-1:0]     burst_cnt_reg, burst_cnt_next;
  logic [WIDTH-1:0]    q_reg, q_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic                busy_reg, busy_next;
  logic                ld_done_reg, ld_done_next;
  logic [IDXW-1:0]     ld_src_reg, ld_src_next;

  logic [WIDTH-1:0]    data_arr [NUM_REQ];
  logic [IDXW-1:0]     pick_start;
  logic                pick_valid;
  logic [IDXW-1:0]     pick_idx;

  function automatic logic [IDXW-1:0] inc_wrap(input logic [IDXW-1:0] i);
    return (i == IDXW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts just past the previous owner (IDLE) or the current owner (release).
  assign pick_start = (state_reg == IDLE) ? inc_wrap(last_owner_reg) : inc_wrap(owner_reg);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Next-state: arbitration, loading, burst counting and release with same-edge re-grant.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    burst_cnt_next  = burst_cnt_reg;
    q_next          = q_reg;
    gnt_next        = gnt_reg;
    busy_next       = busy_reg;
    ld_done_next    = 1'b0;
    ld_src_next     = ld_src_reg;

    if (clr) begin
      state_next     = IDLE;
      burst_cnt_next = '0;
      q_next         = '0;
      gnt_next       = '0;
      busy_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_next     = OWNED;
            owner_next     = pick_idx;
            burst_cnt_next = '0;
            gnt_next       = onehot(pick_idx);
            busy_next      = 1'b1;
          end
        end
        OWNED: begin
          if (req[owner_reg]) begin
            q_next         = data_arr[owner_reg];
            ld_done_next   = 1'b1;
            ld_src_next    = owner_reg;
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
          // Release on a dropped request or on the burst's final load.
          if (!req[owner_reg] || (burst_cnt_reg == CNTW'(MAX_BURST - 1))) begin
            last_owner_next = owner_reg;
            burst_cnt_next  = '0;
            if (pick_valid) begin
              owner_next = pick_idx;
              gnt_next   = onehot(pick_idx);
            end else begin
              state_next = IDLE;
              gnt_next   = '0;
              busy_next  = 1'b0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register with asynchronous reset; requester 0 gets first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= IDXW'(NUM_REQ - 1);
      burst_cnt_reg  <= '0;
      q_reg          <= '0;
      gnt_reg        <= '0;
      busy_reg       <= 1'b0;
      ld_done_reg    <= 1'b0;
      ld_src_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      burst_cnt_reg  <= burst_cnt_next;
      q_reg          <= q_next;
      gnt_reg        <= gnt_next;
      busy_reg       <= busy_next;
      ld_done_reg    <= ld_done_next;
      ld_src_reg     <= ld_src_next;
    end
  end

  assign gnt     = gnt_reg;
  assign busy    = busy_reg;
  assign q       = q_reg;
  assign ld_done = ld_done_reg;
  assign ld_src  = ld_src_reg;

endmodule

// File: tb/tb_load_reg_arbiter.sv
// Directed bench for load_reg_arbiter with NUM_REQ=4, WIDTH=8, MAX_BURST=4.
module tb_load_reg_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     clr;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [WIDTH-1:0]         q;
  logic                     ld_done;
  logic [1:0]               ld_src;

  int checks;
  int errors;

  load_reg_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .clr      (clr),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .ld_done  (ld_done),
    .ld_src   (ld_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    clr   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    clr      = 1'b0;

    // Reset state
    step();
    check_val("rst_q", q, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ld_done", ld_done, 0);
    check_val("rst_ld_src", ld_src, 0);
    rst_n = 1'b1;

    // Single requester 2
    req = 4'b0100;
    set_data(2, 8'hA5);
    step();
    check_val("t1_gnt", gnt, 4'b0100);
    check_val("t1_busy", busy, 1);
    check_val("t1_ld_done_pre", ld_done, 0);
    step();
    check_val("t1_q", q, 8'hA5);
    check_val("t1_ld_done", ld_done, 1);
    check_val("t1_ld_src", ld_src, 2);
    req = '0;
    step();
    check_val("t1_idle_gnt", gnt, 0);
    check_val("t1_idle_busy", busy, 0);
    check_val("t1_idle_ld_done", ld_done, 0);
    check_val("t1_hold_q", q, 8'hA5);

    // Burst cap: req0 and req1; last owner was 2 so requester 0 wins first
    req = 4'b0011;
    set_data(0, 8'd1);
    set_data(1, 8'h77);
    step();
    check_val("t2_gnt0", gnt, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      set_data(0, 8'(k));
      step();
      check_val("t2_q", q, k);
      check_val("t2_ld_src", ld_src, 0);
      check_val("t2_ld_done", ld_done, 1);
      check_val("t2_gnt", gnt, (k < 4) ? 4'b0001 : 4'b0010);
      check_val("t2_busy", busy, 1);
    end
    set_data(0, 8'd5);
    step();
    check_val("t2_q_r1", q, 8'h77);
    check_val("t2_ld_src_r1", ld_src, 1);
    check_val("t2_gnt_r1", gnt, 4'b0010);
    req = '0;
    step();
    check_val("t2_idle_gnt", gnt, 0);

    // Fairness: all four requesting from a fresh reset
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hC0 | 8'(i));
    step();
    check_val("t3_gnt_first", gnt, 4'b0001);
    for (int n = 0; n < 20; n++) begin
      int own;
      int nxt;
      own = (n / 4) % 4;
      nxt = (n % 4 == 3) ? (own + 1) % 4 : own;
      step();
      check_val("t3_ld_src", ld_src, own);
      check_val("t3_q", q, 8'hC0 | own);
      check_val("t3_gnt", gnt, 32'(1) << nxt);
    end
    req = '0;
    step();

    // Owner 1 drops early while requester 3 waits
    do_reset();
    req = 4'b0010;
    step();
    check_val("t4_gnt1", gnt, 4'b0010);
    req = 4'b1010;
    set_data(1, 8'h21);
    set_data(3, 8'h33);
    step();
    check_val("t4_q1", q, 8'h21);
    set_data(1, 8'h22);
    step();
    check_val("t4_q2", q, 8'h22);
    check_val("t4_gnt_hold", gnt, 4'b0010);
    req = 4'b1000;
    set_data(1, 8'h23);
    step();
    check_val("t4_gnt3", gnt, 4'b1000);
    check_val("t4_q_kept", q, 8'h22);
    check_val("t4_ld_done_gap", ld_done, 0);
    check_val("t4_busy", busy, 1);
    step();
    check_val("t4_q3", q, 8'h33);
    check_val("t4_ld_src3", ld_src, 3);
    check_val("t4_ld_done3", ld_done, 1);

    // Solo re-grant: requester 0 alone for 10 loads
    do_reset();
    req = 4'b0001;
    step();
    check_val("t5_gnt", gnt, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      set_data(0, 8'h50 + 8'(k));
      step();
      check_val("t5_q", q, 8'h50 + k);
      check_val("t5_ld_done", ld_done, 1);
      check_val("t5_gnt", gnt, 4'b0001);
    end

    // Clear during a load
    set_data(0, 8'hFF);
    clr = 1'b1;
    step();
    check_val("t6_clr_q", q, 0);
    check_val("t6_clr_gnt", gnt, 0);
    check_val("t6_clr_busy", busy, 0);
    check_val("t6_clr_ld_done", ld_done, 0);
    clr = 1'b0;
    set_data(0, 8'h5A);
    step();
    check_val("t6_regnt", gnt, 4'b0001);
    step();
    check_val("t6_q_5a", q, 8'h5A);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_arst_q", q, 0);
    check_val("t6_arst_gnt", gnt, 0);
    check_val("t6_arst_busy", busy, 0);
    check_val("t6_arst_ld_done", ld_done, 0);
    req = '0;
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
